pwm_gate_guard: RTL and testbench

//  Downstream safety stage between the 3-phase PWM generator and the gate-driver pins.

---
 rtl/pwm_gate_guard_if.sv | 22 ++
 rtl/pwm_gate_guard.sv | 190 +++++++++++++++++++
 tb/tb_pwm_gate_guard.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_gate_guard_if.sv
// Gate-guard signal bundle: PWM requests and control in, gate drives and status out.
interface pwm_gate_guard_if;
    logic       en;
    logic       clear_fault;
    logic       fault_n;
    logic [2:0] hi_in;
    logic [2:0] lo_in;
    logic [2:0] hi;
    logic [2:0] lo;
    logic [1:0] state;
    logic [2:0] faults;

    modport master (
        output en, clear_fault, fault_n, hi_in, lo_in,
        input  hi, lo, state, faults
    );

    modport slave (
        input  en, clear_fault, fault_n, hi_in, lo_in,
        output hi, lo, state, faults
    );
endinterface

// File: rtl/pwm_gate_guard.sv
// pwm_gate_guard: safety stage between a 3-phase PWM generator and the gate-driver pins.
// Sequences enable/arming with a bootstrap interval, enforces a per-phase dead-time
// backstop, watches the PWM pattern for stalls and latches fault causes.
module pwm_gate_guard #(
    parameter logic [15:0] GUARD       = 16'd32,
    parameter logic [15:0] BOOT_CYCLES = 16'd1000,
    parameter logic [23:0] WDOG_CYCLES = 24'd250000
) (
    input  logic            c,
    input  logic            rst_n,
    pwm_gate_guard_if.slave bus
);
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ARMING = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SIDE_NONE = 2'd0,
        SIDE_HI   = 2'd1,
        SIDE_LO   = 2'd2
    } side_t;

    state_t      state_reg, state_next;
    logic [2:0]  faults_reg, faults_next;
    logic [2:0]  cause;
    logic [15:0] boot_reg, boot_next;
    logic [23:0] wdog_reg, wdog_next;
    logic [5:0]  prev_in_reg;
    logic        sync_reg, fsync_reg;
    logic [2:0]  hi_reg, lo_reg;
    logic [2:0]  hi_grant, lo_grant;
    logic        in_same, shoot, wdog_hit;

    assign in_same  = ({bus.hi_in, bus.lo_in} == prev_in_reg);
    assign shoot    = |(bus.hi_in & bus.lo_in);
    // Trips on the cycle whose unchanged sample would bring the count to WDOG_CYCLES
    assign wdog_hit = in_same && (wdog_reg >= WDOG_CYCLES - 24'd1);

    // Two-flop synchronizer for the external driver fault; idles at "no fault"
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 1'b1;
            fsync_reg <= 1'b1;
        end else begin
            sync_reg  <= bus.fault_n;
            fsync_reg <= sync_reg;
        end
    end

    // Next-state decision, fault cause collection and bootstrap counting
    always_comb begin
        state_next  = state_reg;
        faults_next = faults_reg;
        boot_next   = boot_reg;
        cause       = 3'b000;
        if (state_reg == ST_FAULT) begin
            // Leaving FAULT needs the fault gone and software disabled
            if (bus.clear_fault && fsync_reg && !bus.en) begin
                state_next  = ST_OFF;
                faults_next = 3'b000;
            end
        end else begin
            cause[0] = !fsync_reg;
            cause[1] = (state_reg == ST_RUN) && shoot;
            cause[2] = (state_reg == ST_RUN) && wdog_hit;
            if (cause != 3'b000) begin
                state_next  = ST_FAULT;
                faults_next = faults_reg | cause;
            end else begin
                case (state_reg)
                    ST_OFF: begin
                        if (bus.en) begin
                            state_next = ST_ARMING;
                            boot_next  = 16'd0;
                        end
                    end
                    ST_ARMING: begin
                        if (!bus.en) begin
                            state_next = ST_OFF;
                        end else if (boot_reg == BOOT_CYCLES - 16'd1) begin
                            state_next = ST_RUN;
                        end else begin
                            boot_next = boot_reg + 16'd1;
                        end
                    end
                    ST_RUN: begin
                        if (!bus.en) begin
                            state_next = ST_OFF;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Pattern watchdog: counts unchanged RUN samples, cleared on change and outside RUN
    always_comb begin
        wdog_next = wdog_reg;
        if (state_reg != ST_RUN || !in_same) begin
            wdog_next = 24'd0;
        end else if (wdog_reg < WDOG_CYCLES) begin
            wdog_next = wdog_reg + 24'd1;
        end
    end

    // Per-phase dead-time backstop: remembers the last conducting side and how long
    // both switches have been off, and refuses a side swap until GUARD has elapsed
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_phase
            side_t       last_reg, last_next;
            logic [15:0] off_reg, off_next;
            logic        req_hi, req_lo, guard_ok;
            logic        hi_g, lo_g;

            assign req_hi   = bus.hi_in[gi] && !bus.lo_in[gi];
            assign req_lo   = bus.lo_in[gi] && !bus.hi_in[gi];
            assign guard_ok = (off_reg >= GUARD);

            // Grant decision for the state being entered, plus tracker update
            always_comb begin
                hi_g      = 1'b0;
                lo_g      = 1'b0;
                last_next = last_reg;
                off_next  = off_reg;
                if (state_next == ST_ARMING) begin
                    lo_g      = 1'b1;
                    last_next = SIDE_LO;
                end else if (state_next == ST_RUN) begin
                    if (req_hi && (last_reg != SIDE_LO || guard_ok)) begin
                        hi_g      = 1'b1;
                        last_next = SIDE_HI;
                    end else if (req_lo && (last_reg != SIDE_HI || guard_ok)) begin
                        lo_g      = 1'b1;
                        last_next = SIDE_LO;
                    end
                end
                if (hi_g || lo_g) begin
                    off_next = 16'd0;
                end else if (off_reg < GUARD) begin
                    off_next = off_reg + 16'd1;
                end
            end

            // Phase tracker registers
            always_ff @(posedge c or negedge rst_n) begin
                if (!rst_n) begin
                    last_reg <= SIDE_NONE;
                    off_reg  <= GUARD;
                end else begin
                    last_reg <= last_next;
                    off_reg  <= off_next;
                end
            end

            assign hi_grant[gi] = hi_g;
            assign lo_grant[gi] = lo_g;
        end
    endgenerate

    // State, counters and registered gate outputs
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_OFF;
            faults_reg  <= 3'b000;
            boot_reg    <= 16'd0;
            wdog_reg    <= 24'd0;
            prev_in_reg <= 6'd0;
            hi_reg      <= 3'b000;
            lo_reg      <= 3'b000;
        end else begin
            state_reg   <= state_next;
            faults_reg  <= faults_next;
            boot_reg    <= boot_next;
            wdog_reg    <= wdog_next;
            prev_in_reg <= {bus.hi_in, bus.lo_in};
            hi_reg      <= hi_grant;
            lo_reg      <= lo_grant;
        end
    end

    assign bus.hi     = hi_reg;
    assign bus.lo     = lo_reg;
    assign bus.state  = state_reg;
    assign bus.faults = faults_reg;
endmodule

// File: tb/tb_pwm_gate_guard.sv
// Self-checking bench for pwm_gate_guard with a behavioural reference model.
module tb_pwm_gate_guard;
    localparam logic [15:0] GUARD = 16'd4;
    localparam logic [15:0] BOOT  = 16'd8;
    localparam logic [23:0] WDOG  = 24'd64;

    logic c     = 1'b0;
    logic rst_n = 1'b1;

    pwm_gate_guard_if bus ();

    pwm_gate_guard #(
        .GUARD       (GUARD),
        .BOOT_CYCLES (BOOT),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .c     (c),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 c = ~c;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference model state: plain integers describing the rules, not the RTL registers
    logic [1:0] m_state;
    logic [2:0] m_faults, m_hi, m_lo;
    int         m_last[3];   // 0 none, 1 high side, 2 low side
    int         m_zero[3];   // cycles since the phase last conducted
    int         m_quiet;     // consecutive unchanged samples while running
    int         m_arm;       // arming cycles completed
    logic [5:0] m_prev;
    logic       m_fs1, m_fs2;

    task automatic model_reset();
        m_state = 2'd0; m_faults = 3'b000; m_hi = 3'b000; m_lo = 3'b000;
        for (int p = 0; p < 3; p++) begin
            m_last[p] = 0;
            m_zero[p] = int'(GUARD);
        end
        m_quiet = 0; m_arm = 0; m_prev = 6'd0; m_fs1 = 1'b1; m_fs2 = 1'b1;
    endtask

    task automatic model_step();
        logic [2:0] hin, lin, cause, nh, nl;
        logic [5:0] cur;
        logic [1:0] ns;
        bit         same;
        hin = bus.hi_in; lin = bus.lo_in; cur = {hin, lin};
        same = (cur == m_prev);
        ns = m_state; cause = 3'b000;
        if (m_state == 2'd3) begin
            if (bus.clear_fault && m_fs2 && !bus.en) begin
                ns = 2'd0; m_faults = 3'b000;
            end
        end else begin
            cause[0] = !m_fs2;
            cause[1] = (m_state == 2'd2) && ((hin & lin) != 3'b000);
            cause[2] = (m_state == 2'd2) && same && (m_quiet + 1 >= int'(WDOG));
            if (cause != 3'b000) begin
                ns = 2'd3; m_faults = m_faults | cause;
            end else if (m_state == 2'd0 && bus.en) begin
                ns = 2'd1; m_arm = 0;
            end else if (m_state == 2'd1 && !bus.en) begin
                ns = 2'd0;
            end else if (m_state == 2'd1 && m_arm + 1 == int'(BOOT)) begin
                ns = 2'd2;
            end else if (m_state == 2'd2 && !bus.en) begin
                ns = 2'd0;
            end
        end
        if (m_state == 2'd1) m_arm++;
        m_quiet = (m_state == 2'd2 && same) ? m_quiet + 1 : 0;
        nh = 3'b000; nl = 3'b000;
        for (int p = 0; p < 3; p++) begin
            if (ns == 2'd1) begin
                nl[p] = 1'b1; m_last[p] = 2;
            end else if (ns == 2'd2) begin
                if (hin[p] && !lin[p] && (m_last[p] != 2 || m_zero[p] >= int'(GUARD))) begin
                    nh[p] = 1'b1; m_last[p] = 1;
                end else if (lin[p] && !hin[p] && (m_last[p] != 1 || m_zero[p] >= int'(GUARD))) begin
                    nl[p] = 1'b1; m_last[p] = 2;
                end
            end
            if (nh[p] || nl[p]) m_zero[p] = 0;
            else if (m_zero[p] < 100000) m_zero[p]++;
        end
        m_hi = nh; m_lo = nl; m_state = ns; m_prev = cur;
        m_fs2 = m_fs1; m_fs1 = bus.fault_n;
    endtask

    // Advance one clock, step the model on the same edge, then settle for sampling
    task automatic tick();
        @(posedge c);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.clear_fault = 1'b0; bus.fault_n = 1'b1;
        bus.hi_in = 3'b000; bus.lo_in = 3'b000;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.state, bus.faults, bus.hi, bus.lo} !== 11'd0) begin
            $display("FAIL reset_async: got %b want %b", {bus.state, bus.faults, bus.hi, bus.lo}, 11'd0);
        end else passed++;
        @(posedge c); @(posedge c); #1;
        rst_n = 1'b1;
        model_reset();
        tick();
        total++;
        if ({bus.state, bus.faults, bus.hi, bus.lo} !== 11'd0) begin
            $display("FAIL reset_idle: got %b want %b", {bus.state, bus.faults, bus.hi, bus.lo}, 11'd0);
        end else passed++;
        $display("reset: state=%0d faults=%b hi=%b lo=%b", bus.state, bus.faults, bus.hi, bus.lo);
    endtask

    task automatic test_arming();
        int arm_cycles;
        arm_cycles = 0;
        bus.hi_in = 3'b000; bus.lo_in = 3'b000; bus.en = 1'b1;
        tick();
        total++;
        if (bus.state !== 2'd1) begin
            $display("FAIL arm_entry: got state %0d want 1", bus.state);
        end else passed++;
        if (bus.state == 2'd1) arm_cycles++;
        for (int i = 0; i < 20; i++) begin
            bus.lo_in = ~bus.lo_in;
            tick();
            total++;
            if ({bus.state, bus.faults, bus.hi, bus.lo} !== {m_state, m_faults, m_hi, m_lo}) begin
                $display("FAIL arm_model cyc=%0d: got %b want %b", cyc,
                         {bus.state, bus.faults, bus.hi, bus.lo}, {m_state, m_faults, m_hi, m_lo});
            end else passed++;
            if (bus.state == 2'd1) arm_cycles++;
            if (bus.state == 2'd2) begin
                total++;
                if (bus.lo !== bus.lo_in || bus.hi !== 3'b000) begin
                    $display("FAIL run_follow cyc=%0d: got hi=%b lo=%b want hi=000 lo=%b", cyc, bus.hi, bus.lo, bus.lo_in);
                end else passed++;
            end
        end
        total++;
        if (arm_cycles != 8) begin
            $display("FAIL arm_length: got %0d cycles want 8", arm_cycles);
        end else passed++;
        $display("arming: %0d arming cycles, now state=%0d", arm_cycles, bus.state);
    endtask

    task automatic go_run();
        bus.en = 1'b1; bus.hi_in = 3'b000; bus.clear_fault = 1'b0;
        for (int i = 0; i < 40 && bus.state != 2'd2; i++) begin
            bus.lo_in = ~bus.lo_in;
            tick();
            total++;
            if ({bus.state, bus.faults, bus.hi, bus.lo} !== {m_state, m_faults, m_hi, m_lo}) begin
                $display("FAIL go_run_model cyc=%0d: got %b want %b", cyc,
                         {bus.state, bus.faults, bus.hi, bus.lo}, {m_state, m_faults, m_hi, m_lo});
            end else passed++;
        end
        total++;
        if (bus.state !== 2'd2) begin
            $display("FAIL go_run_timeout: got state %0d want 2", bus.state);
        end else passed++;
        $display("go_run: state=%0d at cyc=%0d", bus.state, cyc);
    endtask

    task automatic test_deadtime();
        int t_fall, t_rise;
        t_fall = 0; t_rise = -1;
        bus.hi_in = 3'b000; bus.lo_in = 3'b100;
        for (int i = 0; i < 3; i++) tick();
        bus.lo_in = 3'b000;
        tick();
        t_fall = cyc;
        bus.hi_in = 3'b100;
        for (int i = 0; i < 12 && t_rise < 0; i++) begin
            tick();
            total++;
            if ({bus.state, bus.faults, bus.hi, bus.lo} !== {m_state, m_faults, m_hi, m_lo}) begin
                $display("FAIL dead_model cyc=%0d: got %b want %b", cyc,
                         {bus.state, bus.faults, bus.hi, bus.lo}, {m_state, m_faults, m_hi, m_lo});
            end else passed++;
            if (bus.hi[2]) t_rise = cyc;
        end
        total++;
        if (t_rise - t_fall != int'(GUARD)) begin
            $display("FAIL dead_gap: got %0d off cycles want %0d", t_rise - t_fall, GUARD);
        end else passed++;
        tick(); tick();
        bus.hi_in = 3'b000;
        for (int i = 0; i < 10; i++) tick();
        bus.hi_in = 3'b100;
        tick();
        total++;
        if (bus.hi !== 3'b100 || bus.lo !== 3'b000) begin
            $display("FAIL same_side_grant: got hi=%b lo=%b want hi=100 lo=000", bus.hi, bus.lo);
        end else passed++;
        bus.hi_in = 3'b000; bus.lo_in = 3'b100;
        tick();
        total++;
        if ({bus.state, bus.faults, bus.hi, bus.lo} !== {m_state, m_faults, m_hi, m_lo}) begin
            $display("FAIL swap_block: got %b want %b",
                     {bus.state, bus.faults, bus.hi, bus.lo}, {m_state, m_faults, m_hi, m_lo});
        end else passed++;
        $display("deadtime: off gap %0d cycles, hi regrant hi=%b", t_rise - t_fall, bus.hi);
    endtask

    task automatic test_shoot();
        bus.hi_in = 3'b001; bus.lo_in = 3'b001;
        tick();
        total++;
        if ({bus.state, bus.faults, bus.hi, bus.lo} !== {2'd3, 3'b010, 3'b000, 3'b000}) begin
            $display("FAIL shoot_fault: got %b want %b", {bus.state, bus.faults, bus.hi, bus.lo},
                     {2'd3, 3'b010, 3'b000, 3'b000});
        end else passed++;
        bus.hi_in = 3'b000; bus.lo_in = 3'b000; bus.clear_fault = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (bus.state !== 2'd3 || bus.faults !== 3'b010) begin
            $display("FAIL shoot_clear_en: got state %0d faults %b want 3 010", bus.state, bus.faults);
        end else passed++;
        bus.en = 1'b0;
        tick();
        total++;
        if (bus.state !== 2'd0 || bus.faults !== 3'b000) begin
            $display("FAIL shoot_clear: got state %0d faults %b want 0 000", bus.state, bus.faults);
        end else passed++;
        bus.clear_fault = 1'b0;
        $display("shoot: cleared to state=%0d faults=%b", bus.state, bus.faults);
    endtask

    task automatic test_ext_fault();
        go_run();
        bus.hi_in = 3'b000; bus.lo_in = 3'b111;
        tick();
        bus.fault_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({bus.state, bus.faults, bus.hi, bus.lo} !== {m_state, m_faults, m_hi, m_lo}) begin
                $display("FAIL ext_model cyc=%0d: got %b want %b", cyc,
                         {bus.state, bus.faults, bus.hi, bus.lo}, {m_state, m_faults, m_hi, m_lo});
            end else passed++;
        end
        total++;
        if ({bus.state, bus.faults, bus.hi, bus.lo} !== {2'd3, 3'b001, 3'b000, 3'b000}) begin
            $display("FAIL ext_latency: got %b want %b", {bus.state, bus.faults, bus.hi, bus.lo},
                     {2'd3, 3'b001, 3'b000, 3'b000});
        end else passed++;
        bus.en = 1'b0; bus.clear_fault = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (bus.state !== 2'd3) begin
            $display("FAIL ext_clear_held: got state %0d want 3", bus.state);
        end else passed++;
        bus.fault_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({bus.state, bus.faults, bus.hi, bus.lo} !== {m_state, m_faults, m_hi, m_lo}) begin
                $display("FAIL ext_release cyc=%0d: got %b want %b", cyc,
                         {bus.state, bus.faults, bus.hi, bus.lo}, {m_state, m_faults, m_hi, m_lo});
            end else passed++;
        end
        total++;
        if (bus.state !== 2'd0 || bus.faults !== 3'b000) begin
            $display("FAIL ext_clear: got state %0d faults %b want 0 000", bus.state, bus.faults);
        end else passed++;
        bus.clear_fault = 1'b0;
        $display("ext_fault: recovered to state=%0d", bus.state);
    endtask

    task automatic test_watchdog();
        go_run();
        bus.hi_in = 3'b000; bus.lo_in = 3'b010;
        for (int i = 0; i < 64; i++) tick();
        total++;
        if (bus.state !== 2'd2) begin
            $display("FAIL wdog_early: got state %0d want 2", bus.state);
        end else passed++;
        bus.lo_in = 3'b001;
        for (int i = 0; i < 64; i++) begin
            tick();
            total++;
            if ({bus.state, bus.faults, bus.hi, bus.lo} !== {m_state, m_faults, m_hi, m_lo}) begin
                $display("FAIL wdog_model cyc=%0d: got %b want %b", cyc,
                         {bus.state, bus.faults, bus.hi, bus.lo}, {m_state, m_faults, m_hi, m_lo});
            end else passed++;
        end
        total++;
        if (bus.state !== 2'd2) begin
            $display("FAIL wdog_63: got state %0d want 2", bus.state);
        end else passed++;
        tick();
        total++;
        if ({bus.state, bus.faults, bus.hi, bus.lo} !== {2'd3, 3'b100, 3'b000, 3'b000}) begin
            $display("FAIL wdog_trip: got %b want %b", {bus.state, bus.faults, bus.hi, bus.lo},
                     {2'd3, 3'b100, 3'b000, 3'b000});
        end else passed++;
        bus.en = 1'b0; bus.clear_fault = 1'b1;
        tick(); tick();
        bus.clear_fault = 1'b0;
        $display("watchdog: tripped faults=%b, after clear state=%0d", 3'b100, bus.state);
    endtask

    task automatic test_random();
        int fhold;
        fhold = 0;
        bus.en = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            bus.hi_in = 3'($urandom);
            bus.lo_in = 3'($urandom) & ~bus.hi_in;
            if ($urandom_range(0, 149) == 0) bus.en = ~bus.en;
            bus.clear_fault = ($urandom_range(0, 7) == 0);
            if (fhold > 0) begin
                fhold--;
                if (fhold == 0) bus.fault_n = 1'b1;
            end else if ($urandom_range(0, 999) == 0) begin
                bus.fault_n = 1'b0;
                fhold = $urandom_range(1, 5);
            end
            if (i == 6000 || i == 13000) begin
                #2 rst_n = 1'b0;
                #1;
                total++;
                if ({bus.state, bus.faults, bus.hi, bus.lo} !== 11'd0) begin
                    $display("FAIL rand_reset cyc=%0d: got %b want %b", cyc,
                             {bus.state, bus.faults, bus.hi, bus.lo}, 11'd0);
                end else passed++;
                model_reset();
                bus.fault_n = 1'b1; fhold = 0; bus.en = 1'b1;
                @(posedge c); #1;
                rst_n = 1'b1;
                $display("random: mid-run reset at cyc=%0d", cyc);
            end
            tick();
            total++;
            if ({bus.state, bus.faults, bus.hi, bus.lo} !== {m_state, m_faults, m_hi, m_lo}) begin
                $display("FAIL rand_model cyc=%0d: got %b want %b", cyc,
                         {bus.state, bus.faults, bus.hi, bus.lo}, {m_state, m_faults, m_hi, m_lo});
            end else passed++;
            total++;
            if ((bus.hi & bus.lo) !== 3'b000) begin
                $display("FAIL rand_overlap cyc=%0d: got hi&lo=%b want 000", cyc, bus.hi & bus.lo);
            end else passed++;
        end
        $display("random: 20000 cycles done at cyc=%0d", cyc);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_arming();
        test_deadtime();
        test_shoot();
        test_ext_fault();
        test_watchdog();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
